// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register file reads, resolves operands with
// writeback bypass, and presents them on a registered output stage that
// stays coherent with writes arriving while it is stalled.
module operand_fetch #(
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic [4:0]           o_read_register_1,
  output logic [4:0]           o_read_register_2,
  input  logic [31:0]          i_read_data_1,
  input  logic [31:0]          i_read_data_2,
  input  logic                 i_wb_we,
  input  logic [4:0]           i_wb_reg,
  input  logic [31:0]          i_wb_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_op1,
  output logic [31:0]          o_op2,
  output logic [PAYLOAD_W-1:0] o_payload
);

  // S1: instruction whose file read is in flight
  logic                 s1_valid_q, s1_valid_d;
  logic [4:0]           s1_rs1_q, s1_rs1_d;
  logic [4:0]           s1_rs2_q, s1_rs2_d;
  logic [PAYLOAD_W-1:0] s1_payload_q, s1_payload_d;

  // OUT: resolved instruction presented downstream
  logic                 out_valid_q, out_valid_d;
  logic [4:0]           out_rs1_q, out_rs1_d;
  logic [4:0]           out_rs2_q, out_rs2_d;
  logic [31:0]          op1_q, op1_d;
  logic [31:0]          op2_q, op2_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;

  // Previous cycle's writeback; the file read data lags it by one cycle
  logic                 wb_we_q, wb_we_d;
  logic [4:0]           wb_reg_q, wb_reg_d;
  logic [31:0]          wb_data_q, wb_data_d;

  logic advance;
  logic xfer_in;
  logic xfer_out;

  assign advance  = s1_valid_q && (!out_valid_q || i_ready);
  assign o_ready  = !s1_valid_q || advance;
  assign xfer_in  = i_valid && o_ready;
  assign xfer_out = out_valid_q && i_ready;

  // A stalled S1 keeps re-reading its own indices so its data never goes stale
  assign o_read_register_1 = (s1_valid_q && !advance) ? s1_rs1_q : i_rs1;
  assign o_read_register_2 = (s1_valid_q && !advance) ? s1_rs2_q : i_rs2;

  // Outputs read as idle for the whole reset cycle, so nothing transfers then
  assign o_valid   = out_valid_q && !i_reset;
  assign o_op1     = i_reset ? 32'd0 : op1_q;
  assign o_op2     = i_reset ? 32'd0 : op2_q;
  assign o_payload = i_reset ? '0 : out_payload_q;

  // x0 is hard zero; a matching index is nonzero, so writes to x0 never bypass
  function automatic logic [31:0] resolve(
    input logic [4:0]  idx,
    input logic [31:0] file_data,
    input logic        cur_we,
    input logic [4:0]  cur_reg,
    input logic [31:0] cur_data,
    input logic        prv_we,
    input logic [4:0]  prv_reg,
    input logic [31:0] prv_data
  );
    logic [31:0] res;
    if (idx == 5'd0) begin
      res = 32'd0;
    end else if (cur_we && (cur_reg == idx)) begin
      res = cur_data;
    end else if (prv_we && (prv_reg == idx)) begin
      res = prv_data;
    end else begin
      res = file_data;
    end
    return res;
  endfunction

  // Next-state for both stages and the writeback snoop register
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_rs1_d      = s1_rs1_q;
    s1_rs2_d      = s1_rs2_q;
    s1_payload_d  = s1_payload_q;
    out_valid_d   = out_valid_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    out_payload_d = out_payload_q;
    wb_we_d       = i_wb_we;
    wb_reg_d      = i_wb_reg;
    wb_data_d     = i_wb_data;

    if (xfer_in) begin
      s1_valid_d   = 1'b1;
      s1_rs1_d     = i_rs1;
      s1_rs2_d     = i_rs2;
      s1_payload_d = i_payload;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d   = 1'b1;
      out_rs1_d     = s1_rs1_q;
      out_rs2_d     = s1_rs2_q;
      out_payload_d = s1_payload_q;
      op1_d = resolve(s1_rs1_q, i_read_data_1, i_wb_we, i_wb_reg, i_wb_data,
                      wb_we_q, wb_reg_q, wb_data_q);
      op2_d = resolve(s1_rs2_q, i_read_data_2, i_wb_we, i_wb_reg, i_wb_data,
                      wb_we_q, wb_reg_q, wb_data_q);
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      // Held output tracks writes to its sources so it is never stale on release
      if (i_wb_we && (i_wb_reg != 5'd0) && (i_wb_reg == out_rs1_q)) begin
        op1_d = i_wb_data;
      end
      if (i_wb_we && (i_wb_reg != 5'd0) && (i_wb_reg == out_rs2_q)) begin
        op2_d = i_wb_data;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_q    <= 1'b0;
      s1_rs1_q      <= 5'd0;
      s1_rs2_q      <= 5'd0;
      s1_payload_q  <= '0;
      out_valid_q   <= 1'b0;
      out_rs1_q     <= 5'd0;
      out_rs2_q     <= 5'd0;
      op1_q         <= 32'd0;
      op2_q         <= 32'd0;
      out_payload_q <= '0;
      wb_we_q       <= 1'b0;
      wb_reg_q      <= 5'd0;
      wb_data_q     <= 32'd0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_rs1_q      <= s1_rs1_d;
      s1_rs2_q      <= s1_rs2_d;
      s1_payload_q  <= s1_payload_d;
      out_valid_q   <= out_valid_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      out_payload_q <= out_payload_d;
      wb_we_q       <= wb_we_d;
      wb_reg_q      <= wb_reg_d;
      wb_data_q     <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register file environment, an architectural
// register model and an in-order scoreboard of accepted instructions.
module tb_operand_fetch;

  localparam int unsigned PW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [4:0]    i_rs1, i_rs2;
  logic [PW-1:0] i_payload;
  logic [4:0]    o_read_register_1, o_read_register_2;
  logic [31:0]   i_read_data_1, i_read_data_2;
  logic          i_wb_we;
  logic [4:0]    i_wb_reg;
  logic [31:0]   i_wb_data;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_op1, o_op2;
  logic [PW-1:0] o_payload;

  always #5 i_clk = ~i_clk;

  operand_fetch #(.PAYLOAD_W(PW)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_rs1             (i_rs1),
    .i_rs2             (i_rs2),
    .i_payload         (i_payload),
    .o_read_register_1 (o_read_register_1),
    .o_read_register_2 (o_read_register_2),
    .i_read_data_1     (i_read_data_1),
    .i_read_data_2     (i_read_data_2),
    .i_wb_we           (i_wb_we),
    .i_wb_reg          (i_wb_reg),
    .i_wb_data         (i_wb_data),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_op1             (o_op1),
    .o_op2             (o_op2),
    .o_payload         (o_payload)
  );

  // Environment register file: synchronous read, read-before-write
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge i_clk) begin
    i_read_data_1 <= rf[o_read_register_1];
    i_read_data_2 <= rf[o_read_register_2];
    if (i_wb_we && (i_wb_reg != 5'd0)) rf[i_wb_reg] <= i_wb_data;
  end

  // Reference: architectural register values plus expected output order
  logic [31:0] arch [32] = '{default: 32'h0};
  typedef struct packed {
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [PW-1:0] payload;
  } instr_t;
  instr_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] arch_val(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : arch[r];
  endfunction

  // One clock: observe handshakes mid-cycle, update the model, advance
  task automatic step();
    instr_t e;
    @(negedge i_clk);
    if (i_reset) begin
      chk("valid_during_reset", {63'd0, o_valid}, 64'd0);
    end else begin
      if (o_valid && i_ready) begin
        chk("output_has_pending_instr", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_payload", {32'd0, o_payload}, {32'd0, e.payload});
          chk("out_op1", {32'd0, o_op1}, {32'd0, arch_val(e.rs1)});
          chk("out_op2", {32'd0, o_op2}, {32'd0, arch_val(e.rs2)});
        end
      end
      if (i_valid && o_ready) begin
        e.rs1 = i_rs1;
        e.rs2 = i_rs2;
        e.payload = i_payload;
        sb.push_back(e);
      end
      if (i_wb_we && (i_wb_reg != 5'd0)) arch[i_wb_reg] = i_wb_data;
    end
    @(posedge i_clk);
    if (i_reset) sb.delete();
    #1;
  endtask

  task automatic idle();
    i_valid   = 1'b0;
    i_wb_we   = 1'b0;
    i_wb_reg  = 5'd0;
    i_wb_data = 32'd0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [PW-1:0] p);
    i_valid   = 1'b1;
    i_rs1     = r1;
    i_rs2     = r2;
    i_payload = p;
  endtask

  task automatic write(input logic [4:0] r, input logic [31:0] d);
    i_wb_we   = 1'b1;
    i_wb_reg  = r;
    i_wb_data = d;
  endtask

  function automatic logic [4:0] rand_reg();
    int unsigned r;
    r = $urandom_range(0, 8);
    return (r == 0) ? 5'd0 : 5'(9 + r);
  endfunction

  initial begin
    i_reset = 1'b1;
    i_ready = 1'b1;
    i_rs1 = 5'd0;
    i_rs2 = 5'd0;
    i_payload = '0;
    idle();
    step();
    step();
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_o_op1", {32'd0, o_op1}, 64'd0);
    chk("rst_o_op2", {32'd0, o_op2}, 64'd0);
    chk("rst_o_payload", {32'd0, o_payload}, 64'd0);
    i_reset = 1'b0;
    #1;
    chk("rst_o_ready", {63'd0, o_ready}, 64'd1);

    // Preload architectural state
    write(5'd5, 32'h11);   step();
    write(5'd6, 32'h22);   step();
    write(5'd9, 32'h99);   step();
    write(5'd7, 32'h1234); step();
    idle();

    // Basic fetch and one-cycle latency
    issue(5'd5, 5'd6, 32'hA0);
    step();
    idle();
    chk("lat_not_yet_valid", {63'd0, o_valid}, 64'd0);
    step();
    chk("basic_valid", {63'd0, o_valid}, 64'd1);
    chk("basic_op1", {32'd0, o_op1}, 64'h11);
    chk("basic_op2", {32'd0, o_op2}, 64'h22);
    chk("basic_payload", {32'd0, o_payload}, 64'hA0);

    // Write to the source in the acceptance cycle
    issue(5'd7, 5'd5, 32'hA1);
    write(5'd7, 32'hDEAD);
    step();
    idle();
    step();
    chk("prior_bypass_op1", {32'd0, o_op1}, 64'hDEAD);
    chk("prior_bypass_op2", {32'd0, o_op2}, 64'h11);

    // x0 sources ignore writes to x0 on every path
    issue(5'd0, 5'd0, 32'hA2);
    write(5'd0, 32'hFFFF);
    step();
    i_valid = 1'b0;
    step();
    chk("x0_op1", {32'd0, o_op1}, 64'd0);
    chk("x0_op2", {32'd0, o_op2}, 64'd0);
    idle();
    step();

    // Output stall with a write during the hold
    i_ready = 1'b0;
    issue(5'd5, 5'd9, 32'hB1);
    step();
    issue(5'd6, 5'd9, 32'hB2);
    step();
    idle();
    chk("hold1_valid", {63'd0, o_valid}, 64'd1);
    chk("hold1_payload", {32'd0, o_payload}, 64'hB1);
    chk("hold1_o_ready", {63'd0, o_ready}, 64'd0);
    step();
    write(5'd9, 32'h55);
    step();
    idle();
    chk("hold2_op2_updated", {32'd0, o_op2}, 64'h55);
    chk("hold2_o_ready", {63'd0, o_ready}, 64'd0);
    step();
    i_ready = 1'b1;
    #1;
    chk("release_op1", {32'd0, o_op1}, 64'h11);
    chk("release_op2", {32'd0, o_op2}, 64'h55);
    chk("release_payload", {32'd0, o_payload}, 64'hB1);
    step();
    chk("next_valid", {63'd0, o_valid}, 64'd1);
    chk("next_payload", {32'd0, o_payload}, 64'hB2);
    chk("next_op1", {32'd0, o_op1}, 64'h22);
    chk("next_op2", {32'd0, o_op2}, 64'h55);
    step();

    // Back-to-back stream at full throughput
    for (int k = 0; k < 4; k++) begin
      issue(5'(5 + k), 5'(6 + k), 32'hC0 + 32'(k));
      #1;
      chk("stream_o_ready", {63'd0, o_ready}, 64'd1);
      step();
      if (k >= 1) begin
        chk("stream_valid", {63'd0, o_valid}, 64'd1);
        chk("stream_payload", {32'd0, o_payload}, 64'hC0 + 64'(k - 1));
      end
    end
    idle();
    step();
    chk("stream_last_valid", {63'd0, o_valid}, 64'd1);
    chk("stream_last_payload", {32'd0, o_payload}, 64'hC3);
    step();

    // Randomized traffic, stalls and writebacks
    for (int n = 0; n < 400; n++) begin
      i_valid   = ($urandom_range(0, 3) != 0);
      i_rs1     = rand_reg();
      i_rs2     = ($urandom_range(0, 4) == 0) ? i_rs1 : rand_reg();
      i_payload = 32'h1000 + 32'(n);
      i_ready   = ($urandom_range(0, 3) != 0);
      i_wb_we   = ($urandom_range(0, 1) != 0);
      i_wb_reg  = rand_reg();
      i_wb_data = $urandom;
      step();
    end
    idle();
    i_ready = 1'b1;
    for (int n = 0; n < 10 && sb.size() != 0; n++) step();
    chk("random_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full
    i_ready = 1'b0;
    issue(5'd5, 5'd6, 32'hD1);
    step();
    issue(5'd6, 5'd5, 32'hD2);
    step();
    idle();
    chk("full_valid", {63'd0, o_valid}, 64'd1);
    chk("full_o_ready", {63'd0, o_ready}, 64'd0);
    i_reset = 1'b1;
    i_ready = 1'b1;
    #1;
    chk("reset_cycle_no_valid", {63'd0, o_valid}, 64'd0);
    step();
    i_reset = 1'b0;
    #1;
    chk("post_rst_valid", {63'd0, o_valid}, 64'd0);
    chk("post_rst_op1", {32'd0, o_op1}, 64'd0);
    chk("post_rst_op2", {32'd0, o_op2}, 64'd0);
    chk("post_rst_payload", {32'd0, o_payload}, 64'd0);
    chk("post_rst_s1_empty", {63'd0, o_ready}, 64'd1);

    // First instruction after reset
    issue(5'd5, 5'd7, 32'hE0);
    step();
    idle();
    chk("post_rst_no_stale_out", {63'd0, o_valid}, 64'd0);
    step();
    chk("after_rst_valid", {63'd0, o_valid}, 64'd1);
    chk("after_rst_payload", {32'd0, o_payload}, 64'hE0);
    chk("after_rst_op1", {32'd0, o_op1}, 64'h11);
    chk("after_rst_op2", {32'd0, o_op2}, 64'hDEAD);
    step();
    step();
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter PAYLOAD_W, default 32, width of the per-instruction sideband (PC/decoded fields) carried alongside operands.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  upstream instruction valid.
REQ-005 o_ready  output  1  block accepts the instruction this cycle.
REQ-006 i_rs1, i_rs2  input  5 each  source register indices.
REQ-007 i_payload  input  PAYLOAD_W  sideband carried unchanged.
REQ-008 o_read_register_1, o_read_register_2  output  5 each  register file read addresses.
REQ-009 i_read_data_1, i_read_data_2  input  32 each  register file read data, valid one cycle after the address is presented.
REQ-010 i_wb_we, i_wb_reg, i_wb_data  input  1/5/32  snoop of the register file write port (same signals the file sees).
REQ-011 o_valid  output  1  operands valid downstream.
REQ-012 i_ready  input  1  downstream accepts this cycle.
REQ-013 o_op1, o_op2  output  32 each  resolved operand values.
REQ-014 o_payload  output  PAYLOAD_W  sideband of the instruction on the output.

Function
REQ-015 Two stages: S1 (address issued, waiting on file data; holds s1_valid, rs1, rs2, payload) and OUT (registered outputs).
REQ-016 Transfer in = i_valid && o_ready; transfer out = o_valid && i_ready.
REQ-017 advance = s1_valid && (!o_valid || i_ready); o_ready = !s1_valid || advance (combinational; no dependency on i_valid).
REQ-018 Read addresses = S1 indices when s1_valid && !advance (re-read each stall cycle); otherwise i_rs1/i_rs2.
REQ-019 On transfer in, S1 loads indices and payload; s1_valid cleared on advance without transfer in.
REQ-020 On advance, OUT loads payload and operands; o_valid set; o_valid cleared on transfer out with no advance.
REQ-021 Operand resolution per source at capture, priority high to low: index 0 -> 0; current i_wb_we && i_wb_reg==index -> i_wb_data; prior-cycle write (registered i_wb_we/reg/data) to index -> its data; else i_read_data_n.
REQ-022 Writes with i_wb_reg==0 are ignored by every bypass path.
REQ-023 While o_valid && !i_ready, any i_wb_we to nonzero register matching an output instruction's rs1/rs2 replaces o_op1/o_op2 that cycle (OUT keeps rs1/rs2 copies).
REQ-024 rs1==rs2 resolves both operands identically, including bypass.
REQ-025 Latency: instruction accepted at edge T appears on o_valid after edge T+1; sustained throughput one instruction per cycle with i_ready held high.
REQ-026 Output stall backpressures: S1 holds, o_ready low once S1 occupied; no instruction dropped or duplicated.
REQ-027 Operands delivered equal architectural register values including all writes up to and including the capture or current hold cycle.

Reset
REQ-028 While i_reset high: s1_valid=0, o_valid=0, o_op1=o_op2=0, o_payload=0, registered writeback state cleared; o_ready=1 after reset deasserts.
REQ-029 Reset mid-operation discards in-flight instructions in S1 and OUT; no output transfer occurs in the reset cycle.
REQ-030 First cycle after reset accepts a new instruction normally.

Verification
REQ-031 x5=0x11, x6=0x22 preloaded; issue rs1=5, rs2=6, payload=0xA0, i_ready=1 -> one cycle later o_valid=1, o_op1=0x11, o_op2=0x22, o_payload=0xA0.
REQ-032 Issue rs1=7 on the same cycle a write x7=0xDEAD occurs -> o_op1=0xDEAD (prior-cycle bypass), not the stale file value.
REQ-033 rs1=0, rs2=0 with concurrent write to reg 0 of 0xFFFF -> o_op1=o_op2=0.
REQ-034 i_ready=0 for 3 cycles holding rs2=9; write x9=0x55 on hold cycle 2 -> o_op2=0x55 when i_ready rises; next instruction in S1 held, o_ready=0, delivered next.
REQ-035 Back-to-back 4 instructions, i_ready=1 -> 4 consecutive o_valid cycles, payloads in order, o_ready stays 1.
REQ-036 Assert i_reset with both stages full -> next cycle o_valid=0, s1 empty, o_op1=o_op2=0, no transfer observed.
